pc_gen_unit: RTL
================

Name: pc_gen_unit

Overview:
Next-generation PC generator for the multi-cycle NPC core. It holds the architectural PC and issues it to the fetch unit over a valid/ready handshake. It advances only when the execute stage commits an instruction. On commit it selects the next PC from four sources: sequential, branch/JAL, JALR, and trap/mret redirection. It also checks target alignment.

Parameters:
XLEN, 32, datapath and PC width.
RESET_VAL, 32'h80000000, PC loaded on reset (XLEN bits).
ALIGN_BITS, 2, low PC bits that must be zero (2 = no C extension, 1 = C extension).
ILEN_BYTES, 4, sequential increment.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
pc  out  XLEN  current PC.
pc_valid  out  1  pc is offered to fetch.
pc_ready  in  1  fetch accepts pc this cycle.
commit_valid  in  1  execute retired the instruction at pc; next-PC controls are valid this cycle.
jump  in  1  take a PC-relative or register target (the former PCAsrc function).
use_rs1  in  1  target base is rs1 instead of pc (JALR; the former PCBsrc function).
imm  in  XLEN  sign-extended offset.
rs1  in  XLEN  register operand.
trap_valid  in  1  take a trap at commit.
trap_vec  in  XLEN  trap target (mtvec).
mret_valid  in  1  return from trap at commit.
mepc  in  XLEN  mret target.
link_pc  out  XLEN  pc + ILEN_BYTES, combinational, for rd writeback.
misalign_err  out  1  one-cycle pulse: the computed jump target was misaligned.
misalign_addr  out  XLEN  offending target, held until the next error.

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-handshake):
  - state=IDLE, pc=RESET_VAL, pc_valid=0, misalign_err=0, misalign_addr=0.
- FSM has three states:
  - IDLE: pc_valid=0. Next cycle goes to ISSUE unconditionally, so the first pc_valid appears 1 cycle after rst deasserts.
  - ISSUE: pc_valid=1. pc_valid must not drop and pc must not change until pc_ready=1. On pc_ready=1 go to WAIT.
  - WAIT: pc_valid=0. Hold until commit_valid=1. On commit, load next_pc into pc, go to ISSUE. Commit-to-new-pc_valid latency is 1 cycle.
- commit_valid outside WAIT is ignored: pc unchanged, no error. The bench flags it as a protocol violation.
- next_pc priority, evaluated only on commit: trap_valid > mret_valid > jump > sequential.
  - Sequential: pc + ILEN_BYTES.
  - jump with use_rs1=0: pc + imm.
  - jump with use_rs1=1: (rs1 + imm) with bit0 forced to 0.
  - trap: trap_vec with low ALIGN_BITS forced to 0.
  - mret: mepc with low ALIGN_BITS forced to 0.
  - All adds are modulo 2^XLEN; wrap-around is silent, with no error.
- Misalignment check applies to jump targets only, after the JALR bit0 clear. It fires if any of the low ALIGN_BITS bits is nonzero. On that commit:
  - pc <= trap_vec (aligned).
  - misalign_err=1 for exactly the following cycle.
  - misalign_addr <= the bad target.
  - State goes to ISSUE as normal.
- Simultaneous trap_valid and misaligned jump: the trap wins and misalign_err stays 0.
- link_pc = pc + ILEN_BYTES, combinational from the registered pc, valid in every state.

Test Plan:
- Reset/sequential:
  - Stimulus: rst for 2 cycles, pc_ready=1, commit 3 times.
  - Required: pc=80000000 with pc_valid high 1 cycle after rst deasserts. Then 80000004, 80000008, 8000000C, with pc_valid low during WAIT.
- Backpressure:
  - Stimulus: pc_ready=0 for 5 cycles in ISSUE, plus a spurious commit_valid.
  - Required: pc_valid stays 1, pc is stable at 80000000, the commit is ignored. Acceptance happens on the cycle pc_ready rises.
- Branch/JALR:
  - Branch: pc=80000010, jump=1, use_rs1=0, imm=FFFFFFF0 -> pc=80000000.
  - JALR: jump=1, use_rs1=1, rs1=80001001, imm=4 -> pc=80001004 (bit0 cleared). link_pc=80000004 before commit.
- Misalignment:
  - Stimulus: ALIGN_BITS=2, pc=80000000, jump=1, imm=2, trap_vec=80000100.
  - Required: pc=80000100, misalign_err pulses 1 cycle, misalign_addr=80000002.
  - Repeat with ALIGN_BITS=1: pc=80000002, no error.
- Priority:
  - trap_valid + mret_valid + jump together -> pc=trap_vec.
  - mret_valid + jump with mepc=80000203 -> pc=80000200.
- Reset mid-operation and wrap:
  - Stimulus: assert rst during WAIT.
  - Required: pc=80000000, IDLE, misalign_addr=0.
  - Wrap: pc=FFFFFFFC sequential commit -> pc=00000000, no error.

Source files
------------

// File: rtl/pc_gen_unit.sv
// Architectural PC holder and next-PC selector for the multi-cycle NPC core.
// Offers pc to fetch over valid/ready and advances only on an execute commit.
module pc_gen_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VAL  = 32'h80000000,
    parameter int              ALIGN_BITS = 2,
    parameter int              ILEN_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    input  logic            pc_ready,
    input  logic            commit_valid,
    input  logic            jump,
    input  logic            use_rs1,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] link_pc,
    output logic            misalign_err,
    output logic [XLEN-1:0] misalign_addr
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [XLEN-1:0] LOW_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [XLEN-1:0] ILEN_INC = XLEN'(ILEN_BYTES);

    function automatic logic [XLEN-1:0] align_down(input logic [XLEN-1:0] a);
        return a & ~LOW_MASK;
    endfunction

    state_t          state, state_nxt;
    logic            commit_fire;
    logic [XLEN-1:0] jmp_base;
    logic [XLEN-1:0] jmp_sum;
    logic [XLEN-1:0] jmp_tgt;
    logic            jmp_misaligned;
    logic            take_misalign;
    logic [XLEN-1:0] next_pc;

    assign link_pc = pc + ILEN_INC;

    // Jump target: JALR clears bit0 before the alignment check.
    assign jmp_base       = use_rs1 ? rs1 : pc;
    assign jmp_sum        = jmp_base + imm;
    assign jmp_tgt        = use_rs1 ? {jmp_sum[XLEN-1:1], 1'b0} : jmp_sum;
    assign jmp_misaligned = |(jmp_tgt & LOW_MASK);

    assign commit_fire   = (state == WAIT) && commit_valid;
    assign take_misalign = !trap_valid && !mret_valid && jump && jmp_misaligned;

    always_comb begin
        next_pc = link_pc;
        if (trap_valid) begin
            next_pc = align_down(trap_vec);
        end else if (mret_valid) begin
            next_pc = align_down(mepc);
        end else if (jump) begin
            next_pc = jmp_misaligned ? align_down(trap_vec) : jmp_tgt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_valid  = 1'b0;
        unique case (state)
            IDLE:  state_nxt = ISSUE;
            ISSUE: begin
                pc_valid = 1'b1;
                if (pc_ready) state_nxt = WAIT;
            end
            WAIT:  if (commit_valid) state_nxt = ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_VAL;
            misalign_err  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            state        <= state_nxt;
            misalign_err <= commit_fire && take_misalign;
            if (commit_fire) begin
                pc <= next_pc;
                if (take_misalign) misalign_addr <= jmp_tgt;
            end
        end
    end

endmodule
